// File: rtl/ad7671_scan_sequencer.sv
// Autonomous conversion sequencer for the four-chip AD7671 front end.
// Settles the ADG408 mux, fires a shared conversion, waits for every BUSY to
// drop, then reads U1..U4 off the shared data bus and publishes a 64-bit frame.
module ad7671_scan_sequencer #(
    parameter int unsigned SETTLE_CYC  = 16,
    parameter int unsigned CNV_LOW_CYC = 2,
    parameter int unsigned RD_LOW_CYC  = 3,
    parameter int unsigned BUSY_TMO    = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        cont_i,
    input  logic        auto_inc_i,
    input  logic [2:0]  chan_sel_i,
    input  logic        err_clr_i,
    input  logic [3:0]  busy_i,
    input  logic [15:0] adc_d_i,
    output logic [2:0]  mux_a_o,
    output logic        cnvst_n_o,
    output logic [3:0]  rd_n_o,
    output logic [63:0] data_out_o,
    output logic        data_valid_o,
    output logic [7:0]  frame_cnt_o,
    output logic        active_o,
    output logic        timeout_err_o
);

    localparam int unsigned CntW = 16;
    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYC - 1);
    localparam logic [CntW-1:0] CnvLast    = CntW'(CNV_LOW_CYC - 1);
    localparam logic [CntW-1:0] RdLast     = CntW'(RD_LOW_CYC - 1);
    localparam logic [CntW-1:0] RdGap      = CntW'(RD_LOW_CYC);
    localparam logic [CntW-1:0] TmoLast    = CntW'(BUSY_TMO - 1);
    // Two synchronizer stages plus one cycle so a late BUSY rise is not missed.
    localparam logic [CntW-1:0] WaitLast   = CntW'(2);

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StCnv,
        StWait,
        StRead,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] tmo_q, tmo_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      busy_s1_q, sbusy_q;
    logic [63:0]     shadow_q, shadow_d;
    logic [63:0]     data_out_q, data_out_d;
    logic [2:0]      mux_q, mux_d;
    logic [7:0]      frame_q, frame_d;
    logic            err_q, err_d;
    logic            cnvst_n_q, cnvst_n_d;
    logic [3:0]      rd_n_q, rd_n_d;
    logic            dv_q, dv_d;

    // Bring the asynchronous BUSY lines into the clock domain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_s1_q <= '0;
            sbusy_q   <= '0;
        end else begin
            busy_s1_q <= busy_i;
            sbusy_q   <= busy_s1_q;
        end
    end

    // State, counters and registered (glitch-free) strobes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            tmo_q      <= '0;
            idx_q      <= '0;
            shadow_q   <= '0;
            data_out_q <= '0;
            mux_q      <= '0;
            frame_q    <= '0;
            err_q      <= 1'b0;
            cnvst_n_q  <= 1'b1;
            rd_n_q     <= 4'hF;
            dv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            data_out_q <= data_out_d;
            mux_q      <= mux_d;
            frame_q    <= frame_d;
            err_q      <= err_d;
            cnvst_n_q  <= cnvst_n_d;
            rd_n_q     <= rd_n_d;
            dv_q       <= dv_d;
        end
    end

    // Frame sequencing; strobes are decoded from the next state so they leave a flop.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        tmo_d      = tmo_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        data_out_d = data_out_q;
        mux_d      = mux_q;
        frame_d    = frame_q;
        err_d      = err_q & ~err_clr_i;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start_i) begin
                    mux_d   = chan_sel_i;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    state_d = StCnv;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end
            end
            StCnv: begin
                tmo_d = tmo_q + 1'b1;
                if (cnt_q == CnvLast) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end
            end
            StWait: begin
                tmo_d = tmo_q + 1'b1;
                if (cnt_q >= WaitLast) begin
                    cnt_d = cnt_q;
                end
                if (cnt_q >= WaitLast && sbusy_q == 4'b0000) begin
                    state_d = StRead;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (tmo_q == TmoLast) begin
                    // A timeout wins over a simultaneous err_clr.
                    state_d = StIdle;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end
            end
            StRead: begin
                if (cnt_q == RdLast) begin
                    shadow_d[{idx_q, 4'b0000} +: 16] = adc_d_i;
                end
                if (cnt_q == RdGap) begin
                    cnt_d = '0;
                    if (idx_q == 2'd3) begin
                        state_d    = StDone;
                        data_out_d = shadow_q;
                        frame_d    = frame_q + 8'd1;
                        if (auto_inc_i) begin
                            mux_d = mux_q + 3'd1;
                        end
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            StDone: begin
                cnt_d   = '0;
                state_d = cont_i ? StSettle : StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        cnvst_n_d = (state_d != StCnv);
        rd_n_d    = 4'hF;
        if (state_d == StRead && cnt_d < RdGap) begin
            rd_n_d[idx_d] = 1'b0;
        end
        dv_d = (state_d == StDone);
    end

    assign mux_a_o       = mux_q;
    assign cnvst_n_o     = cnvst_n_q;
    assign rd_n_o        = rd_n_q;
    assign data_out_o    = data_out_q;
    assign data_valid_o  = dv_q;
    assign frame_cnt_o   = frame_q;
    assign active_o      = (state_q != StIdle);
    assign timeout_err_o = err_q;

endmodule

// File: tb/tb_ad7671_scan_sequencer.sv
// Bench for the AD7671 scan sequencer: a behavioural four-chip ADC model
// (BUSY timing, per-chip sample, bus drive on RD) plus a frame-level scoreboard.
module tb_ad7671_scan_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        start, cont, auto_inc, err_clr;
    logic [2:0]  chan_sel;
    logic [3:0]  busy_r;
    logic [15:0] adc_d;
    logic [2:0]  mux_a_o;
    logic        cnvst_n_o;
    logic [3:0]  rd_n_o;
    logic [63:0] data_out_o;
    logic        data_valid_o;
    logic [7:0]  frame_cnt_o;
    logic        active_o;
    logic        timeout_err_o;

    ad7671_scan_sequencer dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_n),
        .start_i      (start),
        .cont_i       (cont),
        .auto_inc_i   (auto_inc),
        .chan_sel_i   (chan_sel),
        .err_clr_i    (err_clr),
        .busy_i       (busy_r),
        .adc_d_i      (adc_d),
        .mux_a_o      (mux_a_o),
        .cnvst_n_o    (cnvst_n_o),
        .rd_n_o       (rd_n_o),
        .data_out_o   (data_out_o),
        .data_valid_o (data_valid_o),
        .frame_cnt_o  (frame_cnt_o),
        .active_o     (active_o),
        .timeout_err_o(timeout_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ADC model and scoreboard state
    int          cyc = 0, fall_cyc = 0, evt_cyc = 0, all_low_cyc = 0;
    int          cnv_len = 0, rd_len = 0, rd_idx = 0, dv_cnt = 0;
    bit          all_low_seen = 0, conv_active = 0, fixed_samp = 0;
    int unsigned blen [4];
    logic [15:0] samp [4];
    logic [7:0]  exp_cnt;
    logic [2:0]  exp_mux;
    logic        prev_cnvst, prev_active, prev_err;
    logic [3:0]  prev_rd_low, rd_low;
    logic [2:0]  mux_log [$];

    // Selected chip drives the shared bus while its RD is low.
    assign adc_d = !rd_n_o[0] ? samp[0] :
                   !rd_n_o[1] ? samp[1] :
                   !rd_n_o[2] ? samp[2] :
                   !rd_n_o[3] ? samp[3] : 16'hDEAD;

    initial begin
        for (int k = 0; k < 4; k++) samp[k] = '0;
        busy_r = '0; exp_cnt = '0; exp_mux = '0;
        prev_cnvst = 1'b1; prev_active = 1'b0; prev_err = 1'b0; prev_rd_low = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_n) begin
                conv_active = 0; busy_r = '0; exp_cnt = '0; exp_mux = '0;
                rd_idx = 0; all_low_seen = 0; cnv_len = 0; rd_len = 0;
                prev_cnvst = 1'b1; prev_active = 1'b0; prev_err = 1'b0; prev_rd_low = '0;
            end else begin
                cyc++;
                if (active_o && !prev_active) begin
                    exp_mux = chan_sel;
                    evt_cyc = cyc;
                end
                if (!cnvst_n_o && prev_cnvst) begin
                    check("settle_gap", ((cyc - evt_cyc) >= 16) ? 16 : (cyc - evt_cyc), 16);
                    check("mux_at_cnv", mux_a_o, exp_mux);
                    mux_log.push_back(mux_a_o);
                    fall_cyc = cyc; conv_active = 1; rd_idx = 0; cnv_len = 0; all_low_seen = 0;
                    for (int k = 0; k < 4; k++)
                        samp[k] = fixed_samp ? 16'(16'h1111 * (k + 1)) : 16'($urandom);
                end
                if (!cnvst_n_o) cnv_len++;
                if (cnvst_n_o && !prev_cnvst) check("cnv_len", cnv_len, 2);
                if (conv_active) begin
                    for (int k = 0; k < 4; k++)
                        busy_r[k] = (unsigned'(cyc - fall_cyc) < blen[k]);
                    if (busy_r == 4'b0 && !all_low_seen) begin
                        all_low_cyc = cyc; all_low_seen = 1;
                    end
                end
                rd_low = ~rd_n_o;
                if (rd_low != 4'b0 && rd_low != prev_rd_low) begin
                    check("rd_onehot", $countones(rd_low), 1);
                    check("rd_order", rd_low, 4'b0001 << rd_idx);
                    if (rd_idx == 0) begin
                        int g;
                        g = all_low_seen ? (cyc - all_low_cyc) : 0;
                        check("rd_after_busy", (g >= 2) ? 2 : g, 2);
                    end
                    rd_idx++;
                    rd_len = 0;
                end
                if (rd_low != 4'b0) rd_len++;
                if (rd_low == 4'b0 && prev_rd_low != 4'b0) check("rd_len", rd_len, 3);
                if (data_valid_o) begin
                    dv_cnt++;
                    exp_cnt = exp_cnt + 8'd1;
                    if (auto_inc) exp_mux = exp_mux + 3'd1;
                    check("data_out", data_out_o, {samp[3], samp[2], samp[1], samp[0]});
                    check("frame_cnt", frame_cnt_o, exp_cnt);
                    check("mux_after", mux_a_o, exp_mux);
                    check("reads", rd_idx, 4);
                    conv_active = 0; busy_r = '0; evt_cyc = cyc;
                end
                if (timeout_err_o && !prev_err) begin
                    check("tmo_time", cyc - fall_cyc, 255);
                    check("tmo_reads", rd_idx, 0);
                    conv_active = 0; busy_r = '0;
                end
                prev_cnvst = cnvst_n_o; prev_active = active_o;
                prev_err = timeout_err_o; prev_rd_low = rd_low;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk_i); #1 start = 1'b1;
        @(posedge clk_i); #1 start = 1'b0;
    endtask

    task automatic wait_dv(output int lat);
        lat = 1;
        forever begin
            @(negedge clk_i);
            lat++;
            if (data_valid_o) break;
            if (lat > 600) begin
                check("dv_wait", 0, 1);
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (active_o && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        check("idle_wait", active_o, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk_i); #2 rst_n = 1'b0;
        repeat (2) @(negedge clk_i);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected end of test");
        $fatal(1);
    end

    initial begin
        int lat, dv0, n;
        logic [63:0] dout;
        logic [7:0]  fc;
        start = 0; cont = 0; auto_inc = 0; err_clr = 0; chan_sel = '0;
        for (int k = 0; k < 4; k++) blen[k] = 10;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_cnvst", cnvst_n_o, 1'b1);
        check("rst_rd", rd_n_o, 4'hF);
        check("rst_mux", mux_a_o, 3'd0);
        check("rst_dout", data_out_o, 64'd0);
        check("rst_dv", data_valid_o, 1'b0);
        check("rst_fcnt", frame_cnt_o, 8'd0);
        check("rst_active", active_o, 1'b0);
        check("rst_err", timeout_err_o, 1'b0);
        repeat (2) @(negedge clk_i);
        #2 rst_n = 1'b1;

        // Single frame with fixed samples.
        fixed_samp = 1; chan_sel = 3'd5; mux_log.delete();
        pulse_start();
        wait_dv(lat);
        check("single_data", data_out_o, 64'h4444_3333_2222_1111);
        check("single_cnt", frame_cnt_o, 8'd1);
        @(negedge clk_i);
        check("single_idle", active_o, 1'b0);
        check("single_mux", mux_log[0], 3'd5);
        fixed_samp = 0;

        // Minimum-latency frame: BUSY clears as early as the guard allows.
        for (int k = 0; k < 4; k++) blen[k] = 2;
        pulse_start();
        wait_dv(lat);
        check("latency", lat, 39);
        wait_idle(10);

        // Randomized frames; odd ones get a second start during WAIT.
        for (int i = 0; i < 6; i++) begin
            chan_sel = 3'($urandom_range(0, 7));
            auto_inc = 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++)
                blen[k] = (i % 2 == 1) ? $urandom_range(10, 40) : $urandom_range(0, 40);
            dv0 = dv_cnt;
            pulse_start();
            if (i % 2 == 1) begin
                repeat (18) @(negedge clk_i);
                pulse_start();
            end
            wait_dv(lat);
            wait_idle(10);
            repeat (3) @(negedge clk_i);
            #1;
            check("one_frame", dv_cnt - dv0, 1);
            check("no_restart", active_o, 1'b0);
        end
        auto_inc = 0;

        // Staggered BUSY release.
        blen[0] = 5; blen[1] = 8; blen[2] = 12; blen[3] = 20;
        pulse_start();
        wait_dv(lat);
        wait_idle(10);

        // BUSY timeout; cont must not restart afterwards.
        cont = 1; blen[0] = 0; blen[1] = 0; blen[2] = 100000; blen[3] = 0;
        dout = data_out_o; fc = frame_cnt_o; dv0 = dv_cnt;
        pulse_start();
        wait_idle(400);
        check("tmo_flag", timeout_err_o, 1'b1);
        repeat (5) @(negedge clk_i);
        #1;
        check("tmo_no_cont", active_o, 1'b0);
        check("tmo_dout", data_out_o, dout);
        check("tmo_fcnt", frame_cnt_o, fc);
        check("tmo_no_dv", dv_cnt - dv0, 0);
        @(posedge clk_i); #1 err_clr = 1'b1;
        @(posedge clk_i); #1 err_clr = 1'b0;
        @(negedge clk_i);
        check("err_clr", timeout_err_o, 1'b0);

        // Timeout while err_clr is held: set wins on the timeout edge.
        cont = 0; err_clr = 1'b1;
        pulse_start();
        wait_idle(400);
        check("tmo_clr_same", timeout_err_o, 1'b1);
        @(negedge clk_i);
        check("tmo_clr_next", timeout_err_o, 1'b0);
        err_clr = 1'b0;

        // Continuous auto-increment from a fresh reset.
        do_reset();
        mux_log.delete();
        chan_sel = 3'd6; cont = 1; auto_inc = 1;
        for (int k = 0; k < 4; k++) blen[k] = $urandom_range(0, 15);
        dv0 = dv_cnt;
        pulse_start();
        wait_dv(lat);
        wait_dv(lat);
        repeat (3) @(negedge clk_i);
        cont = 0;
        wait_dv(lat);
        wait_idle(10);
        repeat (2) @(negedge clk_i);
        #1;
        check("cont_dv", dv_cnt - dv0, 3);
        check("cont_fcnt", frame_cnt_o, 8'd3);
        check("cont_mux_end", mux_a_o, 3'd1);
        check("cont_log_n", mux_log.size(), 3);
        if (mux_log.size() >= 3) begin
            check("cont_mux0", mux_log[0], 3'd6);
            check("cont_mux1", mux_log[1], 3'd7);
            check("cont_mux2", mux_log[2], 3'd0);
        end
        auto_inc = 0;

        // Asynchronous reset while U2 is being read.
        for (int k = 0; k < 4; k++) blen[k] = 3;
        pulse_start();
        n = 0;
        while (rd_n_o[1] && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check("rd1_seen", rd_n_o[1], 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_rd", rd_n_o, 4'hF);
        check("arst_cnvst", cnvst_n_o, 1'b1);
        check("arst_dv", data_valid_o, 1'b0);
        check("arst_active", active_o, 1'b0);
        check("arst_dout", data_out_o, 64'd0);
        dv0 = dv_cnt;
        repeat (2) @(negedge clk_i);
        #2 rst_n = 1'b1;
        repeat (50) @(negedge clk_i);
        #1;
        check("arst_no_dv", dv_cnt - dv0, 0);
        check("arst_dout_hold", data_out_o, 64'd0);
        check("arst_fcnt", frame_cnt_o, 8'd0);
        check("arst_idle", active_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
